// File: rtl/pipe_ops_pkg.sv
// pipe_ops_pkg
// Shared opcode definitions for the pipeline opcode tracker and the
// branch/load hazard detector that reads it.
//   OPW      - opcode width
//   NOP_OP   - opcode used for bubbles, flushes and reset
//   OP_*     - opcode classes the hazard detector decodes
//   mode_e   - per-cycle pipeline mode (RUN, FLUSH, STALL)
//   selectMode() - mode decode with priority STALL > FLUSH > RUN
package pipe_ops_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] NOP_OP  = 4'b0000;
  localparam logic [OPW-1:0] OP_ATYPE = 4'b0001;
  localparam logic [OPW-1:0] OP_LW_A  = 4'b0100;
  localparam logic [OPW-1:0] OP_LW_B  = 4'b0110;
  localparam logic [OPW-1:0] OP_BR0   = 4'b1100;
  localparam logic [OPW-1:0] OP_BR1   = 4'b1101;
  localparam logic [OPW-1:0] OP_BR2   = 4'b1110;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } mode_e;

  // A stalled branch has not resolved yet, so a stall request always
  // overrides a taken branch in the same cycle.
  function automatic mode_e selectMode(input logic stopPc, input logic branchTaken);
    if (stopPc) begin
      return STALL;
    end else if (branchTaken) begin
      return FLUSH;
    end
    return RUN;
  endfunction

endpackage

// File: rtl/op_stage_reg.sv
// op_stage_reg
// One opcode pipeline register.
//   Clk    - rising-edge clock
//   ResetN - asynchronous active-low reset, forces Q to NOP_OP
//   Load   - capture D on the next edge
//   Clear  - load NOP_OP on the next edge (wins over Load)
//   D      - incoming opcode
//   Q      - registered opcode
// With neither Load nor Clear the register holds its value.
module op_stage_reg
  import pipe_ops_pkg::*;
(
  input  logic           Clk,
  input  logic           ResetN,
  input  logic           Load,
  input  logic           Clear,
  input  logic [OPW-1:0] D,
  output logic [OPW-1:0] Q
);

  // Clear inserts a NOP bubble; otherwise Load advances the stage, and
  // when neither is asserted the stage keeps its opcode (stall hold).
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Q <= NOP_OP;
    end else if (Clear) begin
      Q <= NOP_OP;
    end else if (Load) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/op_pipe_stall_ctrl.sv
// op_pipe_stall_ctrl
// Response end of the stall handshake. Tracks the opcode in each of the
// ID/EX/MEM/WB stages, turns the hazard detector's stall request and the
// ID-stage branch-taken flush into pipeline write enables, and keeps
// stall statistics plus a sticky stall watchdog.
//   Clk, ResetN            - clock, asynchronous active-low reset
//   IFOP                   - opcode currently in IF (next ID candidate)
//   StopPC                 - stall request for this cycle
//   BranchTaken            - branch in ID resolved taken this cycle
//   IDOP/EXOP/MEMOP/WBOP   - registered per-stage opcodes
//   PCWrite, IFIDWrite     - PC and IF/ID load enables (combinational)
//   IFIDFlush, IDEXBubble  - IF/ID clear and ID/EX bubble (combinational)
//   StallCount             - consecutive stall cycles, saturating at 255
//   StallTotal             - total stall cycles since reset, saturating
//   StallTimeout           - sticky, set when StallCount reaches MAX_STALL
//   StallRelease           - one-cycle pulse on the first edge after a stall
module op_pipe_stall_ctrl
  import pipe_ops_pkg::*;
#(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [OPW-1:0]   IFOP,
  input  logic             StopPC,
  input  logic             BranchTaken,
  output logic [OPW-1:0]   IDOP,
  output logic [OPW-1:0]   EXOP,
  output logic [OPW-1:0]   MEMOP,
  output logic [OPW-1:0]   WBOP,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [7:0]       StallCount,
  output logic [CNT_W-1:0] StallTotal,
  output logic             StallTimeout,
  output logic             StallRelease
);

  localparam logic [7:0] MaxStallC = 8'(MAX_STALL);

  mode_e      mode;
  logic       isStall;
  logic       isFlush;
  logic       isRun;
  logic [7:0] countNext;

  // Mode decode and the combinational handshake back to fetch/decode.
  // PC and IF/ID freeze only on a stall; a flush still fetches the
  // branch target but drops the wrong-path op sitting in IF.
  always_comb begin
    mode       = selectMode(StopPC, BranchTaken);
    isStall    = (mode == STALL);
    isFlush    = (mode == FLUSH);
    isRun      = (mode == RUN);
    PCWrite    = !isStall;
    IFIDWrite  = !isStall;
    IFIDFlush  = isFlush;
    IDEXBubble = isStall;
  end

  // ID: holds on stall, clears on flush, otherwise takes the IF opcode.
  op_stage_reg u_id (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Load   (isRun),
    .Clear  (isFlush),
    .D      (IFOP),
    .Q      (IDOP)
  );

  // EX: receives a bubble while ID is frozen, else advances from ID.
  op_stage_reg u_ex (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Load   (1'b1),
    .Clear  (isStall),
    .D      (IDOP),
    .Q      (EXOP)
  );

  // MEM and WB always advance; stalls only freeze the front end.
  op_stage_reg u_mem (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Load   (1'b1),
    .Clear  (1'b0),
    .D      (EXOP),
    .Q      (MEMOP)
  );

  op_stage_reg u_wb (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Load   (1'b1),
    .Clear  (1'b0),
    .D      (MEMOP),
    .Q      (WBOP)
  );

  // Saturating successor of the consecutive-stall count; also used to
  // detect the edge on which the watchdog threshold is reached.
  always_comb begin
    countNext = (StallCount == 8'hFF) ? StallCount : StallCount + 8'd1;
  end

  // Stall statistics and watchdog. StallCount is non-zero exactly when
  // the previous edge was a stall, so it doubles as the history bit for
  // the release pulse. The timeout is informational and sticky.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      StallCount   <= 8'd0;
      StallTotal   <= '0;
      StallTimeout <= 1'b0;
      StallRelease <= 1'b0;
    end else begin
      StallRelease <= !isStall && (StallCount != 8'd0);
      if (isStall) begin
        StallCount <= countNext;
        if (StallTotal != {CNT_W{1'b1}}) begin
          StallTotal <= StallTotal + 1'b1;
        end
        if (countNext == MaxStallC) begin
          StallTimeout <= 1'b1;
        end
      end else begin
        StallCount <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_op_pipe_stall_ctrl.sv
// tb_op_pipe_stall_ctrl
// Directed bench for op_pipe_stall_ctrl. A reference model describes the
// pipeline as an array of four stage opcodes and plain integer counters;
// a compare process checks every output against it on each falling edge,
// and the directed sequence adds hand-computed literal expectations.
module tb_op_pipe_stall_ctrl;
  import pipe_ops_pkg::*;

  localparam int MAX_STALL = 8;
  localparam int CNT_W     = 16;
  localparam int TOTAL_MAX = (1 << CNT_W) - 1;

  logic             Clk;
  logic             ResetN;
  logic [OPW-1:0]   IFOP;
  logic             StopPC;
  logic             BranchTaken;
  logic [OPW-1:0]   IDOP, EXOP, MEMOP, WBOP;
  logic             PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
  logic [7:0]       StallCount;
  logic [CNT_W-1:0] StallTotal;
  logic             StallTimeout;
  logic             StallRelease;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Reference state: stage opcodes indexed ID=0 .. WB=3.
  int mPipe[4];
  int mCount;
  int mTotal;
  bit mTimeout;
  bit mRelease;
  bit mPrevStall;

  op_pipe_stall_ctrl #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .IFOP         (IFOP),
    .StopPC       (StopPC),
    .BranchTaken  (BranchTaken),
    .IDOP         (IDOP),
    .EXOP         (EXOP),
    .MEMOP        (MEMOP),
    .WBOP         (WBOP),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .IDEXBubble   (IDEXBubble),
    .StallCount   (StallCount),
    .StallTotal   (StallTotal),
    .StallTimeout (StallTimeout),
    .StallRelease (StallRelease)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL time_limit actual=still_running required=finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: each edge the older stages simply move one step
  // toward WB; the stall/flush rules only decide what enters ID and EX.
  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 4; i++) mPipe[i] = 0;
      mCount = 0; mTotal = 0; mTimeout = 0; mRelease = 0; mPrevStall = 0;
    end else begin
      bit stall, flush;
      int nextPipe[4];
      stall = (StopPC === 1'b1);
      flush = !stall && (BranchTaken === 1'b1);
      nextPipe[3] = mPipe[2];
      nextPipe[2] = mPipe[1];
      nextPipe[1] = stall ? 0 : mPipe[0];
      nextPipe[0] = stall ? mPipe[0] : (flush ? 0 : int'(IFOP));
      mPipe = nextPipe;
      if (stall) begin
        mCount = (mCount < 255) ? mCount + 1 : 255;
        mTotal = (mTotal < TOTAL_MAX) ? mTotal + 1 : TOTAL_MAX;
        if (mCount == MAX_STALL) mTimeout = 1;
      end else begin
        mCount = 0;
      end
      mRelease = !stall && mPrevStall;
      mPrevStall = stall;
    end
  end

  // Compare process: every falling edge, every output against the model.
  always @(negedge Clk) begin
    if (checkEn) begin
      checkOutput("IDOP",  int'(IDOP),  mPipe[0]);
      checkOutput("EXOP",  int'(EXOP),  mPipe[1]);
      checkOutput("MEMOP", int'(MEMOP), mPipe[2]);
      checkOutput("WBOP",  int'(WBOP),  mPipe[3]);
      checkOutput("PCWrite",    int'(PCWrite),    int'(!StopPC));
      checkOutput("IFIDWrite",  int'(IFIDWrite),  int'(!StopPC));
      checkOutput("IFIDFlush",  int'(IFIDFlush),  int'(!StopPC && BranchTaken));
      checkOutput("IDEXBubble", int'(IDEXBubble), int'(StopPC));
      checkOutput("StallCount",   int'(StallCount),   mCount);
      checkOutput("StallTotal",   int'(StallTotal),   mTotal);
      checkOutput("StallTimeout", int'(StallTimeout), int'(mTimeout));
      checkOutput("StallRelease", int'(StallRelease), int'(mRelease));
    end
  end

  // StopPC must never be unknown while out of reset.
  always @(negedge Clk) begin
    if (ResetN === 1'b1) begin
      assert (!$isunknown(StopPC)) else $error("[TB] StopPC unknown");
    end
  end

  // Present one cycle of inputs, let one rising edge consume them, and
  // return just after the edge so registered outputs are settled.
  task automatic applyStimulus(input int op, input bit stop, input bit br);
    IFOP        = OPW'(op);
    StopPC      = stop;
    BranchTaken = br;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkStages(input string tag, input int id, input int ex, input int mem, input int wb);
    checkOutput({tag, "_IDOP"},  int'(IDOP),  id);
    checkOutput({tag, "_EXOP"},  int'(EXOP),  ex);
    checkOutput({tag, "_MEMOP"}, int'(MEMOP), mem);
    checkOutput({tag, "_WBOP"},  int'(WBOP),  wb);
  endtask

  initial begin
    ResetN = 1'b0; IFOP = '0; StopPC = 1'b0; BranchTaken = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkEn = 1;
    checkStages("reset", 0, 0, 0, 0);
    checkOutput("reset_StallCount", int'(StallCount), 0);
    checkOutput("reset_StallTotal", int'(StallTotal), 0);
    checkOutput("reset_StallTimeout", int'(StallTimeout), 0);
    ResetN = 1'b1;

    // Straight-line flow: 1,4,12,6 reaches WB after four edges.
    applyStimulus(1, 0, 0);  checkStages("run1", 1, 0, 0, 0);
    applyStimulus(4, 0, 0);  checkStages("run2", 4, 1, 0, 0);
    applyStimulus(12, 0, 0); checkStages("run3", 12, 4, 1, 0);
    applyStimulus(6, 0, 0);  checkStages("run4", 6, 12, 4, 1);
    checkOutput("run4_PCWrite", int'(PCWrite), 1);
    applyStimulus(12, 0, 0); checkStages("run5", 12, 6, 12, 4);

    // Two-cycle stall with the branch opcode sitting in ID.
    applyStimulus(3, 1, 0);  checkStages("stall1", 12, 0, 6, 12);
    checkOutput("stall1_PCWrite", int'(PCWrite), 0);
    checkOutput("stall1_IFIDWrite", int'(IFIDWrite), 0);
    checkOutput("stall1_IDEXBubble", int'(IDEXBubble), 1);
    checkOutput("stall1_StallCount", int'(StallCount), 1);
    applyStimulus(3, 1, 0);  checkStages("stall2", 12, 0, 0, 6);
    checkOutput("stall2_StallCount", int'(StallCount), 2);
    applyStimulus(13, 0, 0); checkStages("release", 13, 12, 0, 0);
    checkOutput("release_pulse", int'(StallRelease), 1);
    checkOutput("release_StallTotal", int'(StallTotal), 2);
    checkOutput("release_StallCount", int'(StallCount), 0);

    // Taken branch flushes the wrong-path op fetched in IF.
    applyStimulus(5, 0, 1);  checkStages("flush", 0, 13, 12, 0);
    checkOutput("flush_IFIDFlush", int'(IFIDFlush), 1);
    checkOutput("flush_release_gone", int'(StallRelease), 0);
    applyStimulus(7, 0, 0);  checkStages("postflush", 7, 0, 13, 12);
    checkOutput("postflush_IFIDFlush", int'(IFIDFlush), 0);

    // Stall and taken branch together: stall wins.
    applyStimulus(9, 1, 1);  checkStages("both", 7, 0, 0, 13);
    checkOutput("both_IFIDFlush", int'(IFIDFlush), 0);
    checkOutput("both_IDEXBubble", int'(IDEXBubble), 1);
    applyStimulus(9, 0, 0);  checkStages("both_after", 9, 7, 0, 0);

    // Watchdog: trips on the eighth consecutive stall edge, stays set.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(2, 1, 0);
      if (i == 7) checkOutput("wd_before", int'(StallTimeout), 0);
    end
    checkOutput("wd_trip", int'(StallTimeout), 1);
    checkOutput("wd_count", int'(StallCount), 8);
    checkOutput("wd_total", int'(StallTotal), 11);
    applyStimulus(2, 0, 0);
    checkOutput("wd_sticky", int'(StallTimeout), 1);
    checkOutput("wd_count_clear", int'(StallCount), 0);

    // Consecutive-stall counter saturates at 255.
    for (int i = 0; i < 260; i++) applyStimulus(1, 1, 0);
    checkOutput("sat_count", int'(StallCount), 255);
    checkOutput("sat_total", int'(StallTotal), 271);
    applyStimulus(1, 0, 0);
    checkOutput("sat_release", int'(StallRelease), 1);

    // Asynchronous reset in the middle of a stall, between edges.
    applyStimulus(3, 1, 0);
    applyStimulus(3, 1, 0);
    #2;
    ResetN = 1'b0;
    #1;
    checkStages("areset", 0, 0, 0, 0);
    checkOutput("areset_StallCount", int'(StallCount), 0);
    checkOutput("areset_StallTotal", int'(StallTotal), 0);
    checkOutput("areset_StallTimeout", int'(StallTimeout), 0);
    checkOutput("areset_StallRelease", int'(StallRelease), 0);
    StopPC = 1'b0;
    #3;
    ResetN = 1'b1;
    applyStimulus(1, 0, 0);  checkStages("resume1", 1, 0, 0, 0);
    checkOutput("resume_release", int'(StallRelease), 0);
    applyStimulus(4, 0, 0);  checkStages("resume2", 4, 1, 0, 0);
    applyStimulus(6, 0, 0);
    applyStimulus(0, 0, 0);
    @(negedge Clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
